// File: rtl/ps2_host_tx_funcmod_if.sv
// ps2_host_tx_funcmod_if: command handshake between the controlling logic
// and the PS/2 host transmitter (request, byte, busy/done/error status).
interface ps2_host_tx_funcmod_if;
    logic       iStart;
    logic [7:0] iData;
    logic       oBusy;
    logic       oDone;
    logic       oErr;

    modport master (
        output iStart,
        output iData,
        input  oBusy,
        input  oDone,
        input  oErr
    );

    modport slave (
        input  iStart,
        input  iData,
        output oBusy,
        output oDone,
        output oErr
    );
endinterface

// File: rtl/ps2_host_tx_funcmod.sv
// ps2_host_tx_funcmod: PS/2 host-to-device command transmitter (open-collector pull-down enables).
// Optional watchdog abort on a silent device: define PS2TX_TIMEOUT_EN.
module ps2_host_tx_funcmod #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    ps2_host_tx_funcmod_if.slave        host,
    input  logic                        PS2_CLK,
    input  logic                        PS2_DAT,
    output logic                        oClkLow,
    output logic                        oDatLow
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] INHIBIT = 3'd1;
    localparam logic [2:0] SHIFT   = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] ACK     = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2TX_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic             clkS1, clkS2, clkPrev;
    logic             datS1, datS2;
    logic             fall;

    logic [2:0]       state;
    logic [8:0]       shiftData;
    logic [3:0]       idx;
    logic [INH_W-1:0] inhCnt;
    logic             busy, done, err;
    logic             clkLow, datLow;

    logic [WD_W-1:0]  wdCnt;
    logic             inFrame;
    logic             wdFire;

    // Bring the asynchronous pins into the CLOCK domain; idle level is high.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            clkS1   <= 1'b1;
            clkS2   <= 1'b1;
            clkPrev <= 1'b1;
            datS1   <= 1'b1;
            datS2   <= 1'b1;
        end else begin
            clkS1   <= PS2_CLK;
            clkS2   <= clkS1;
            clkPrev <= clkS2;
            datS1   <= PS2_DAT;
            datS2   <= datS1;
        end
    end

    assign fall    = clkPrev & ~clkS2;
    assign inFrame = (state == SHIFT) || (state == STOP) || (state == ACK);

    // Watchdog: restarts on every device edge, only runs while the device clocks the frame.
    always_ff @(posedge CLOCK) begin
        if (RESET || !WD_EN) begin
            wdCnt <= '0;
        end else if (!inFrame || fall) begin
            wdCnt <= '0;
        end else if (!wdFire) begin
            wdCnt <= wdCnt + 1'b1;
        end
    end

    assign wdFire = WD_EN && inFrame && (wdCnt == WD_LAST);

    // Host request sequence: inhibit, start, data, parity, stop, ACK sample.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= IDLE;
            shiftData <= '0;
            idx       <= '0;
            inhCnt    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            clkLow    <= 1'b0;
            datLow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (host.iStart) begin
                        shiftData <= {~^host.iData, host.iData};
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        clkLow    <= 1'b1;
                        inhCnt    <= '0;
                        state     <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inhCnt == INH_LAST) begin
                        clkLow <= 1'b0;
                        datLow <= 1'b1;
                        idx    <= '0;
                        inhCnt <= '0;
                        state  <= SHIFT;
                    end else begin
                        inhCnt <= inhCnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        datLow <= ~shiftData[idx];
                        idx    <= idx + 1'b1;
                        if (idx == 4'd8) begin
                            state <= STOP;
                        end
                    end else if (wdFire) begin
                        clkLow <= 1'b0;
                        datLow <= 1'b0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                STOP: begin
                    if (fall) begin
                        datLow <= 1'b0;
                        state  <= ACK;
                    end else if (wdFire) begin
                        clkLow <= 1'b0;
                        datLow <= 1'b0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                ACK: begin
                    if (fall) begin
                        err   <= datS2;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (wdFire) begin
                        clkLow <= 1'b0;
                        datLow <= 1'b0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: begin
                    clkLow <= 1'b0;
                    datLow <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign oClkLow    = clkLow;
    assign oDatLow    = datLow;
    assign host.oBusy = busy;
    assign host.oDone = done;
    assign host.oErr  = err;

endmodule
